// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the serializer/deserializer
// state encodings.
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = AES_BLOCK_W / AES_BYTE_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/aes_block_serializer.sv
// Holds one cyphertext block and streams it out MSB byte first
// over a valid/ready byte interface.
module aes_block_serializer
    import aes_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W,
    parameter int BYTE_W  = AES_BYTE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLOCK_W-1:0] blk_data,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic [BYTE_W-1:0]  byte_data,
    output logic               busy,
    output logic [3:0]         byte_idx
);

    localparam int NUM_BYTES = BLOCK_W / BYTE_W;
    localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

    ser_state_e         state_q, state_d;
    logic [BLOCK_W-1:0] shreg_q, shreg_d;
    logic [3:0]         idx_q, idx_d;

    logic sending;
    logic hs;
    logic last;

    assign sending = (state_q == S_SEND);
    assign hs      = sending & byte_ready;
    assign last    = (idx_q == LAST_IDX);

    // Ready in the last-byte cycle lets the next block follow with no bubble.
    assign blk_ready  = ~sending | (hs & last);
    assign byte_valid = sending;
    assign busy       = sending;
    assign byte_idx   = idx_q;
    assign byte_data  = sending ? shreg_q[BLOCK_W-1 -: BYTE_W] : '0;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (blk_valid) begin
                    shreg_d = blk_data;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (hs) begin
                    if (!last) begin
                        shreg_d = shreg_q << BYTE_W;
                        idx_d   = idx_q + 4'd1;
                    end else if (blk_valid) begin
                        shreg_d = blk_data;
                        idx_d   = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed vector bench for the AES block serializer.
module tb_aes_block_serializer;

    typedef struct {
        logic         rst;
        logic         bv;
        logic [127:0] bd;
        logic         br;
        logic         ev;
        logic [7:0]   ed;
        logic [3:0]   ei;
        logic         er;
        logic         eb;
        logic         cd;
    } vec_t;

    localparam logic [127:0] BLK_V = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BLK_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BLK_B = 128'hffeeddccbbaa99887766554433221100;
    localparam int EXP_HS = 102;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic         byte_valid;
    logic         byte_ready;
    logic [7:0]   byte_data;
    logic         busy;
    logic [3:0]   byte_idx;

    vec_t vq[$];
    int   applied = 0;
    int   errors  = 0;
    int   hs_cnt  = 0;

    always #5 clk = ~clk;

    aes_block_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .busy       (busy),
        .byte_idx   (byte_idx)
    );

    always @(posedge clk)
        if (!rst && byte_valid === 1'b1 && byte_ready === 1'b1)
            hs_cnt <= hs_cnt + 1;

    function automatic logic [7:0] byte_of(input logic [127:0] b, input int i);
        return b[127 - 8*i -: 8];
    endfunction

    task automatic add(input logic r, input logic bv, input logic [127:0] bd,
                       input logic br, input logic ev, input logic [7:0] ed,
                       input logic [3:0] ei, input logic er, input logic eb,
                       input logic cd);
        vec_t v;
        v.rst = r;  v.bv = bv; v.bd = bd; v.br = br;
        v.ev  = ev; v.ed = ed; v.ei = ei; v.er = er;
        v.eb  = eb; v.cd = cd;
        vq.push_back(v);
    endtask

    // Idle cycle: offer block (or not) and expect the IDLE outputs.
    task automatic add_idle(input logic bv, input logic [127:0] bd);
        add(1'b0, bv, bd, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic add_stream(input logic [127:0] blk, input logic bv,
                              input logic [127:0] bd);
        for (int i = 0; i < 16; i++)
            add(1'b0, bv, bd, 1'b1, 1'b1, byte_of(blk, i), 4'(i),
                (i == 15), 1'b1, 1'b1);
    endtask

    initial begin
        int k;
        int c;
        logic r;
        logic [3:0] pat;

        // Reset: two cycles with blk_valid high, then release.
        add(1'b1, 1'b1, BLK_A, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1);
        add_idle(1'b0, '0);
        add_idle(1'b0, '0);

        // Single block, byte_ready held high.
        add_idle(1'b1, BLK_V);
        add_stream(BLK_V, 1'b0, '0);
        add_idle(1'b0, '0);

        // Backpressure: ready pattern 1,0,0,1 repeating.
        pat = 4'b1001;
        add_idle(1'b1, BLK_V);
        k = 0;
        c = 0;
        while (k < 16) begin
            r = pat[3 - (c % 4)];
            add(1'b0, 1'b0, '0, r, 1'b1, byte_of(BLK_V, k), 4'(k),
                r && (k == 15), 1'b1, 1'b1);
            if (r) k++;
            c++;
        end
        add_idle(1'b0, '0);

        // Back-to-back: B held valid from the cycle after A is taken.
        add_idle(1'b1, BLK_A);
        add_stream(BLK_A, 1'b1, BLK_B);
        add_stream(BLK_B, 1'b0, '0);
        add_idle(1'b0, '0);

        // Block offered mid-stream and withdrawn must be ignored.
        add_idle(1'b1, BLK_V);
        for (int i = 0; i < 16; i++)
            add(1'b0, (i >= 3 && i <= 5), BLK_A, 1'b1, 1'b1,
                byte_of(BLK_V, i), 4'(i), (i == 15), 1'b1, 1'b1);
        add_idle(1'b0, '0);

        // Reset after byte 5 is accepted, then a fresh block.
        add_idle(1'b1, BLK_A);
        for (int i = 0; i < 6; i++)
            add(1'b0, 1'b0, '0, 1'b1, 1'b1, byte_of(BLK_A, i), 4'(i),
                1'b0, 1'b1, 1'b1);
        add(1'b1, 1'b1, BLK_B, 1'b0, 1'b1, byte_of(BLK_A, 6), 4'd6,
            1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, '0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1);
        add_idle(1'b1, BLK_B);
        add_stream(BLK_B, 1'b0, '0);
        add_idle(1'b0, '0);

        // First reset cycle: outputs are unknown before the first edge.
        rst        = 1'b1;
        blk_valid  = 1'b1;
        blk_data   = BLK_B;
        byte_ready = 1'b1;
        @(posedge clk);

        foreach (vq[n]) begin
            logic bad;
            @(negedge clk);
            rst        = vq[n].rst;
            blk_valid  = vq[n].bv;
            blk_data   = vq[n].bd;
            byte_ready = vq[n].br;
            #1;
            applied++;
            bad = (byte_valid !== vq[n].ev) || (byte_idx !== vq[n].ei) ||
                  (blk_ready !== vq[n].er) || (busy !== vq[n].eb) ||
                  ((vq[n].cd || vq[n].ev) && byte_data !== vq[n].ed);
            if (bad) begin
                errors++;
                $display("FAIL vec%0d: got v=%b d=%h i=%0d rdy=%b busy=%b, need v=%b d=%h i=%0d rdy=%b busy=%b",
                         n, byte_valid, byte_data, byte_idx, blk_ready, busy,
                         vq[n].ev, vq[n].ed, vq[n].ei, vq[n].er, vq[n].eb);
            end
        end

        @(negedge clk);
        applied++;
        if (hs_cnt != EXP_HS) begin
            errors++;
            $display("FAIL handshakes: got %0d, need %0d", hs_cnt, EXP_HS);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
